// File: rtl/uart_xcvr_p.sv
// Parametrised full-duplex UART transceiver with a run-time baud divisor and internal loopback.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop bits(1).
module uart_xcvr_p #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              loopback,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    input  logic              rx_line,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);
    localparam int unsigned      IDX_W     = 4;
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = 1'(PARITY_ODD);
    localparam bit               HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t         tx_state, tx_state_n;
    logic [DIV_W-1:0]  tx_div, tx_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [IDX_W-1:0]  tx_idx;
    logic              tx_par, tx_tick, tx_accept;

    assign tx_tick = (tx_cnt == tx_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_n;
    end

    // tx_ready is also high in the final cycle of the last stop bit so a held
    // tx_valid restarts the frame with no idle gap.
    always_comb begin
        tx_state_n = tx_state;
        tx_line    = 1'b1;
        tx_ready   = 1'b0;
        tx_accept  = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_ready = 1'b1;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && tx_idx == DATA_LAST) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_tick) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick && tx_idx == STOP_LAST) begin
                    tx_ready   = 1'b1;
                    tx_state_n = TX_IDLE;
                end
            end
            default:   tx_state_n = TX_IDLE;
        endcase
        if (tx_ready && tx_valid) begin
            tx_accept  = 1'b1;
            tx_state_n = TX_START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_idx   <= '0;
            tx_par   <= 1'b0;
        end else if (tx_accept) begin
            tx_div   <= baud_div;
            tx_cnt   <= '0;
            tx_shift <= tx_data;
            tx_idx   <= '0;
            tx_par   <= (^tx_data) ^ PAR_ODD;
        end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                tx_idx <= (tx_state_n != tx_state) ? '0 : tx_idx + IDX_W'(1);
                if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
            end else begin
                tx_cnt <= tx_cnt + DIV_W'(1);
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t         rx_state, rx_state_n;
    logic              lb_sel, rx_src, sync1, sync2, sync_prev;
    logic [DIV_W-1:0]  rx_div, rx_lim, rx_cnt;
    logic [DIV_W:0]    div_p1;
    logic [DATA_W-1:0] rx_shift;
    logic [IDX_W-1:0]  rx_idx;
    logic              rx_perr_q, rx_ferr_q, rx_tick, rx_start, rx_done;

    assign rx_src  = lb_sel ? tx_line : rx_line;
    assign div_p1  = {1'b0, baud_div} + (DIV_W+1)'(1);
    assign rx_tick = (rx_cnt == ((rx_state == RX_START_CHK) ? rx_lim : rx_div));

    // Loopback select only follows the input while both directions are idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_sel    <= 1'b0;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            rx_state  <= RX_IDLE;
        end else begin
            sync1     <= rx_src;
            sync2     <= sync1;
            sync_prev <= sync2;
            rx_state  <= rx_state_n;
            if (tx_state == TX_IDLE && rx_state == RX_IDLE) lb_sel <= loopback;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_start   = 1'b0;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (sync_prev && !sync2) begin
                    rx_start   = 1'b1;
                    rx_state_n = RX_START_CHK;
                end
            end
            RX_START_CHK: if (rx_tick) rx_state_n = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tick && rx_idx == DATA_LAST) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY:    if (rx_tick) rx_state_n = RX_STOP;
            RX_STOP: begin
                if (rx_tick && rx_idx == STOP_LAST) begin
                    rx_done    = 1'b1;
                    rx_state_n = RX_IDLE;
                end
            end
            default:      rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_div        <= '0;
            rx_lim        <= '0;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_start) begin
                rx_div    <= baud_div;
                rx_lim    <= DIV_W'((div_p1 >> 1) - (DIV_W+1)'(1));
                rx_cnt    <= '0;
                rx_idx    <= '0;
                rx_perr_q <= 1'b0;
                rx_ferr_q <= 1'b0;
            end else if (rx_state != RX_IDLE) begin
                if (rx_tick) begin
                    rx_cnt <= '0;
                    rx_idx <= (rx_state_n != rx_state) ? '0 : rx_idx + IDX_W'(1);
                    case (rx_state)
                        RX_DATA:   rx_shift  <= {sync2, rx_shift[DATA_W-1:1]};
                        RX_PARITY: rx_perr_q <= sync2 ^ (^rx_shift) ^ PAR_ODD;
                        RX_STOP:   rx_ferr_q <= rx_ferr_q | ~sync2;
                        default: ;
                    endcase
                    if (rx_done) begin
                        rx_valid      <= 1'b1;
                        rx_data       <= rx_shift;
                        rx_parity_err <= rx_perr_q;
                        rx_frame_err  <= rx_ferr_q | ~sync2;
                    end
                end else begin
                    rx_cnt <= rx_cnt + DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_xcvr_p.sv
// Self-checking bench for uart_xcvr_p: 8-bit/even-parity/1-stop instance plus a
// 7-bit/no-parity/2-stop instance, checked against a frame-level reference model.
module tb_uart_xcvr_p;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        loopback = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_line;
    logic        rx_line = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_parity_err, rx_frame_err;

    logic [15:0] b_baud_div = 16'd3;
    logic        b_loopback = 1'b1;
    logic [6:0]  b_tx_data = '0;
    logic        b_tx_valid = 1'b0;
    logic        b_tx_ready, b_tx_line;
    logic        b_rx_line = 1'b1;
    logic [6:0]  b_rx_data;
    logic        b_rx_valid, b_rx_parity_err, b_rx_frame_err;

    uart_xcvr_p dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .loopback(loopback),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_line(tx_line),
        .rx_line(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
    );

    uart_xcvr_p #(.DATA_W(7), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .baud_div(b_baud_div), .loopback(b_loopback),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_line(b_tx_line),
        .rx_line(b_rx_line), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_parity_err(b_rx_parity_err), .rx_frame_err(b_rx_frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  data;
        logic        perr;
        logic        ferr;
        int unsigned cyc;
    } rxrec_t;
    rxrec_t rxq[$];
    rxrec_t rxq_b[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1)   rxq.push_back('{9'(rx_data), rx_parity_err, rx_frame_err, cyc});
        if (b_rx_valid === 1'b1) rxq_b.push_back('{9'(b_rx_data), b_rx_parity_err, b_rx_frame_err, cyc});
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string nm, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_win(input string nm, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
        end
    endtask

    // Reference model: frame bit k is element k of the returned vector.
    function automatic logic [15:0] mk_frame(input int dw, input int pen, input int podd, input int unsigned d);
        logic [15:0] f = '1;
        int unsigned ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < dw; i++) begin
            f[1+i] = 1'((d >> i) & 1);
            ones += (d >> i) & 1;
        end
        if (pen != 0) f[1+dw] = 1'((ones + podd) % 2);
        return f;
    endfunction

    function automatic logic [10:0] rx_model(input logic [15:0] f, input int dw, input int pen,
                                             input int podd, input int ns);
        int unsigned d = 0;
        int unsigned ones = 0;
        logic perr = 1'b0;
        logic ferr = 1'b0;
        for (int i = 0; i < dw; i++) begin
            d += int'(f[1+i]) << i;
            ones += int'(f[1+i]);
        end
        if (pen != 0) perr = (f[1+dw] != 1'((ones + podd) % 2));
        for (int j = 0; j < ns; j++) if (f[1+dw+pen+j] == 1'b0) ferr = 1'b1;
        return {ferr, perr, 9'(d)};
    endfunction

    function automatic int lat_of(input int nb, input int p);
        return 1 + (nb - 1) * p + p / 2 + 2;
    endfunction

    task automatic send(input int sel, input logic [7:0] d, input bit hold, output int unsigned acc);
        int unsigned n = 0;
        if (sel == 0) begin tx_data = d; tx_valid = 1'b1; end
        else begin b_tx_data = d[6:0]; b_tx_valid = 1'b1; end
        while (((sel == 0) ? tx_ready : b_tx_ready) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: tx_ready never high");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) begin
            if (sel == 0) tx_valid = 1'b0;
            else b_tx_valid = 1'b0;
        end
    endtask

    task automatic tx_watch(input int sel, input logic [15:0] f, input int nb, input int p, input string nm);
        for (int k = 0; k < nb * p; k++) begin
            @(negedge clk);
            check(nm, (sel == 0) ? tx_line : b_tx_line, f[k/p]);
        end
    endtask

    task automatic drive_rx(input logic [15:0] f, input int nb, input int p);
        for (int k = 0; k < nb * p; k++) begin
            rx_line = f[k/p];
            @(negedge clk);
        end
    endtask

    task automatic expect_rx(input int sel, input logic [8:0] ed, input logic ep, input logic ef,
                             input int unsigned acc, input int lat, input string nm);
        rxrec_t r;
        int unsigned n = 0;
        while (((sel == 0) ? rxq.size() : rxq_b.size()) == 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (((sel == 0) ? rxq.size() : rxq_b.size()) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no rx_valid, expected data 0x%0h", nm, ed);
        end else begin
            if (sel == 0) r = rxq.pop_front();
            else r = rxq_b.pop_front();
            check({nm, "_data"}, r.data, ed);
            check({nm, "_perr"}, r.perr, ep);
            check({nm, "_ferr"}, r.ferr, ef);
            if (lat != 0) check_win({nm, "_lat"}, int'(r.cyc - acc), lat - 1, lat + 1);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          flip_par;
        bit          bad_stop;
        int unsigned div;
        logic [7:0]  exp_data;
        bit          exp_perr;
        bit          exp_ferr;
    } ext_vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_vec_t    vecs[5];
        logic [15:0] f;
        logic [10:0] m;
        int unsigned acc, acc2, d, dv, p;

        vecs[0] = '{8'h3C, 1'b1, 1'b0, 7, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'h81, 1'b0, 1'b1, 5, 8'h81, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 3, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 4, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 9, 8'h5A, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx_line", tx_line, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_perr", rx_parity_err, 0);
        check("rst_ferr", rx_frame_err, 0);
        rst = 1'b0;
        loopback = 1'b1;
        repeat (4) @(negedge clk);

        // Basic loopback 0xA5, baud_div=3.
        baud_div = 16'd3;
        send(0, 8'hA5, 0, acc);
        tx_watch(0, 16'b0000_0101_0100_1010, 11, 4, "a5_tx_line");
        expect_rx(0, 9'h0A5, 1'b0, 1'b0, acc, lat_of(11, 4), "a5_rx");

        // Back-to-back 0x00 then 0xFF with tx_valid held.
        send(0, 8'h00, 1, acc);
        tx_data = 8'hFF;
        tx_watch(0, mk_frame(8, 1, 0, 8'h00), 11, 4, "b2b0_tx_line");
        @(posedge clk);
        #1;
        acc2 = cyc;
        tx_valid = 1'b0;
        tx_watch(0, mk_frame(8, 1, 0, 8'hFF), 11, 4, "b2b1_tx_line");
        expect_rx(0, 9'h000, 1'b0, 1'b0, acc, lat_of(11, 4), "b2b0_rx");
        expect_rx(0, 9'h0FF, 1'b0, 1'b0, acc2, lat_of(11, 4), "b2b1_rx");

        // Randomized loopback transfers, divisor changed between frames.
        for (int i = 0; i < 6; i++) begin
            d  = $urandom_range(255, 0);
            dv = $urandom_range(10, 3);
            baud_div = 16'(dv);
            send(0, 8'(d), 0, acc);
            tx_watch(0, mk_frame(8, 1, 0, d), 11, dv + 1, "rnd_lb_tx_line");
            expect_rx(0, 9'(d), 1'b0, 1'b0, acc, lat_of(11, dv + 1), "rnd_lb_rx");
        end

        // External rx_line vectors.
        loopback = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            p = vecs[i].div + 1;
            baud_div = 16'(vecs[i].div);
            f = mk_frame(8, 1, 0, vecs[i].data);
            if (vecs[i].flip_par) f[9] = ~f[9];
            if (vecs[i].bad_stop) f[10] = 1'b0;
            drive_rx(f, 11, p);
            rx_line = 1'b1;
            repeat (2 * p) @(negedge clk);
            expect_rx(0, 9'(vecs[i].exp_data), vecs[i].exp_perr, vecs[i].exp_ferr, 0, 0, "vec_rx");
        end

        // Randomized external frames with occasional parity/stop corruption.
        for (int i = 0; i < 8; i++) begin
            d  = $urandom_range(255, 0);
            dv = $urandom_range(10, 3);
            baud_div = 16'(dv);
            f = mk_frame(8, 1, 0, d);
            if ($urandom_range(3, 0) == 0) f[9] = ~f[9];
            if ($urandom_range(3, 0) == 0) f[10] = 1'b0;
            m = rx_model(f, 8, 1, 0, 1);
            drive_rx(f, 11, dv + 1);
            rx_line = 1'b1;
            repeat (2 * (dv + 1)) @(negedge clk);
            expect_rx(0, m[8:0], m[9], m[10], 0, 0, "rnd_ext_rx");
        end

        // Break: 0x81 with low stop bit, then line held low for 50 bit periods.
        baud_div = 16'd5;
        f = mk_frame(8, 1, 0, 8'h81);
        f[10] = 1'b0;
        drive_rx(f, 11, 6);
        expect_rx(0, 9'h081, 1'b0, 1'b1, 0, 0, "break_rx");
        repeat (50 * 6) @(negedge clk);
        check("break_no_restart", rxq.size(), 0);
        rx_line = 1'b1;
        repeat (12) @(negedge clk);
        drive_rx(mk_frame(8, 1, 0, 8'h5A), 11, 6);
        rx_line = 1'b1;
        expect_rx(0, 9'h05A, 1'b0, 1'b0, 0, 0, "after_break_rx");

        // One-clock glitch at baud_div=15 must not start a frame.
        baud_div = 16'd15;
        repeat (4) @(negedge clk);
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * 16) @(negedge clk);
        check("glitch_no_rx", rxq.size(), 0);
        drive_rx(mk_frame(8, 1, 0, 8'h5A), 11, 16);
        rx_line = 1'b1;
        expect_rx(0, 9'h05A, 1'b0, 1'b0, 0, 0, "glitch_then_rx");

        // Reset during data bit 3 of a loopback frame.
        loopback = 1'b1;
        baud_div = 16'd3;
        repeat (4) @(negedge clk);
        send(0, 8'hC3, 0, acc);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx_line", tx_line, 1);
        check("midrst_tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_no_rx", rxq.size(), 0);
        send(0, 8'h11, 0, acc);
        tx_watch(0, mk_frame(8, 1, 0, 8'h11), 11, 4, "post_rst_tx_line");
        expect_rx(0, 9'h011, 1'b0, 1'b0, acc, lat_of(11, 4), "post_rst_rx");

        // 7-bit, no parity, 2 stop bits instance.
        b_baud_div = 16'd3;
        send(1, 8'h55, 0, acc);
        tx_watch(1, mk_frame(7, 0, 0, 8'h55), 10, 4, "b55_tx_line");
        expect_rx(1, 9'h055, 1'b0, 1'b0, acc, lat_of(10, 4), "b55_rx");
        for (int i = 0; i < 4; i++) begin
            d  = $urandom_range(127, 0);
            dv = $urandom_range(9, 3);
            b_baud_div = 16'(dv);
            send(1, 8'(d), 0, acc);
            tx_watch(1, mk_frame(7, 0, 0, d), 10, dv + 1, "b_rnd_tx_line");
            expect_rx(1, 9'(d), 1'b0, 1'b0, acc, lat_of(10, dv + 1), "b_rnd_rx");
        end

        repeat (20) @(negedge clk);
        check("spurious_rx_a", rxq.size(), 0);
        check("spurious_rx_b", rxq_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
